chk_move_scan: RTL and testbench

- Multi-cycle legal-move scanner for the checkers ALU.
- Takes the mover's pieces, the opponent's pieces and the king mask as 32-bit board states. Scans the four diagonal directions using one shared border-filling neighbour shifter, then reports which own pieces can make a simple move and which can capture.
- Sits directly downstream of the board-shift stage and feeds the CPU's move-legality and forced-capture logic.

---
 rtl/chk_board_pkg.sv | 24 ++
 rtl/chk_dir_shift.sv | 33 +++
 rtl/chk_move_scan.sv | 166 ++++++++++++++++
 tb/tb_chk_move_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_board_pkg.sv
// Shared board geometry, direction and FSM encodings for the checkers move scanner.
package chk_board_pkg;

    localparam int unsigned BOARD_W  = 32;
    localparam int unsigned ROW_W    = 4;
    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned PHASE_W  = 2;

    typedef enum logic [1:0] {
        DIR_UR = 2'd0,
        DIR_UL = 2'd1,
        DIR_DR = 2'd2,
        DIR_DL = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [BOARD_W-1:0] board_t;

endpackage

// File: rtl/chk_dir_shift.sv
// Diagonal neighbour shifter: y[i] = x[neighbour(i)], with off-board neighbours reading as 1.
module chk_dir_shift
    import chk_board_pkg::*;
(
    input  dir_e   dir,
    input  board_t x,
    output board_t y
);

    logic [4:0] sq;
    logic [1:0] col;
    logic [2:0] row;

    always_comb begin
        y   = '1;
        sq  = '0;
        col = '0;
        row = '0;
        for (int unsigned i = 0; i < BOARD_W; i++) begin
            sq  = 5'(i);
            col = sq[1:0];
            row = sq[4:2];
            unique case (dir)
                DIR_UR: if (col != 2'(ROW_W-1) && row != 3'd0)            y[i] = x[sq - 5'd3];
                DIR_UL: if (col != 2'd0        && row != 3'd0)            y[i] = x[sq - 5'd5];
                DIR_DR: if (col != 2'(ROW_W-1) && row != 3'(NUM_ROWS-1))  y[i] = x[sq + 5'd5];
                DIR_DL: if (col != 2'd0        && row != 3'(NUM_ROWS-1))  y[i] = x[sq + 5'd3];
                default: y[i] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/chk_move_scan.sv
// Multi-cycle legal-move scanner: 3 phases x 4 directions through one shared shifter.
// Optional CHK_FORCE_JUMP_EN: suppress simple moves whenever any capture exists.
module chk_move_scan
    import chk_board_pkg::*;
#(
    parameter int unsigned BOARD_W = 32,
    parameter int unsigned ROW_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               side,
    input  logic [BOARD_W-1:0] own,
    input  logic [BOARD_W-1:0] opp,
    input  logic [BOARD_W-1:0] kings,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] move_mask,
    output logic [BOARD_W-1:0] jump_mask,
    output logic               any_jump
);

    if (BOARD_W != 32 || ROW_W != 4) begin : g_bad_geometry
        $error("chk_move_scan supports only BOARD_W=32, ROW_W=4");
    end

    state_e               state_q, state_d;
    dir_e                 dir_q, dir_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 side_q, side_d;
    board_t               own_q, own_d, opp_q, opp_d, kings_q, kings_d;
    board_t               occ1_q, occ1_d, opp1_q, opp1_d;
    board_t               move_acc_q, move_acc_d, jump_acc_q, jump_acc_d;
    board_t               move_mask_q, move_mask_d, jump_mask_q, jump_mask_d;
    logic                 any_jump_q, any_jump_d;
    logic                 done_q, done_d;
    board_t               shift_x, shift_y, mover;

    chk_dir_shift u_shift (
        .dir (dir_q),
        .x   (shift_x),
        .y   (shift_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UR;
            phase_q     <= '0;
            side_q      <= 1'b0;
            own_q       <= '0;
            opp_q       <= '0;
            kings_q     <= '0;
            occ1_q      <= '0;
            opp1_q      <= '0;
            move_acc_q  <= '0;
            jump_acc_q  <= '0;
            move_mask_q <= '0;
            jump_mask_q <= '0;
            any_jump_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            side_q      <= side_d;
            own_q       <= own_d;
            opp_q       <= opp_d;
            kings_q     <= kings_d;
            occ1_q      <= occ1_d;
            opp1_q      <= opp1_d;
            move_acc_q  <= move_acc_d;
            jump_acc_q  <= jump_acc_d;
            move_mask_q <= move_mask_d;
            jump_mask_q <= jump_mask_d;
            any_jump_q  <= any_jump_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (phase_q == 2'd2 && dir_q == DIR_DL) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Backward directions only move kings; forward is UR/UL for side 0, DR/DL for side 1.
    always_comb begin
        mover = (dir_q[1] == side_q) ? own_q : (own_q & kings_q);
        unique case (phase_q)
            2'd0:    shift_x = own_q | opp_q;
            2'd1:    shift_x = opp_q;
            default: shift_x = occ1_q;
        endcase
    end

    always_comb begin
        dir_d       = dir_q;
        phase_d     = phase_q;
        side_d      = side_q;
        own_d       = own_q;
        opp_d       = opp_q;
        kings_d     = kings_q;
        occ1_d      = occ1_q;
        opp1_d      = opp1_q;
        move_acc_d  = move_acc_q;
        jump_acc_d  = jump_acc_q;
        move_mask_d = move_mask_q;
        jump_mask_d = jump_mask_q;
        any_jump_d  = any_jump_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                own_d      = own;
                opp_d      = opp;
                kings_d    = kings & own;
                side_d     = side;
                move_acc_d = '0;
                jump_acc_d = '0;
                dir_d      = DIR_UR;
                phase_d    = '0;
            end
            SCAN: begin
                unique case (phase_q)
                    2'd0: begin
                        occ1_d  = shift_y;
                        phase_d = 2'd1;
                    end
                    2'd1: begin
                        opp1_d  = shift_y;
                        phase_d = 2'd2;
                    end
                    default: begin
                        // shift_y here is occ2 (two squares along dir), consumed without a register.
                        move_acc_d = move_acc_q | (mover & ~occ1_q);
                        jump_acc_d = jump_acc_q | (mover & opp1_q & ~shift_y);
                        phase_d    = '0;
                        dir_d      = dir_e'(dir_q + 2'd1);
                    end
                endcase
            end
            DONE: begin
`ifdef CHK_FORCE_JUMP_EN
                move_mask_d = (jump_acc_q != '0) ? '0 : move_acc_q;
`else
                move_mask_d = move_acc_q;
`endif
                jump_mask_d = jump_acc_q;
                any_jump_d  = |jump_acc_q;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q == SCAN) || (state_q == DONE);
    assign done      = done_q;
    assign move_mask = move_mask_q;
    assign jump_mask = jump_mask_q;
    assign any_jump  = any_jump_q;

endmodule

// File: tb/tb_chk_move_scan.sv
// Scoreboard bench for chk_move_scan; honours CHK_FORCE_JUMP_EN in its expectations.
module tb_chk_move_scan;

    typedef struct packed {
        logic [31:0] mv;
        logic [31:0] jp;
        logic        aj;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        side  = 1'b0;
    logic [31:0] own   = '0;
    logic [31:0] opp   = '0;
    logic [31:0] kings = '0;
    logic        busy, done, any_jump;
    logic [31:0] move_mask, jump_mask;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    chk_move_scan #(.BOARD_W(32), .ROW_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .side      (side),
        .own       (own),
        .opp       (opp),
        .kings     (kings),
        .busy      (busy),
        .done      (done),
        .move_mask (move_mask),
        .jump_mask (jump_mask),
        .any_jump  (any_jump)
    );

    always #5 clock = ~clock;

    function automatic int nb(input int i, input int d);
        int r, c;
        r = i / 4;
        c = i % 4;
        case (d)
            0:       return (c < 3 && r > 0) ? i - 3 : -1;
            1:       return (c > 0 && r > 0) ? i - 5 : -1;
            2:       return (c < 3 && r < 7) ? i + 5 : -1;
            default: return (c > 0 && r < 7) ? i + 3 : -1;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] o, p, k, input logic s);
        exp_t e;
        logic [31:0] occ;
        int n1, n2;
        e   = '0;
        occ = o | p;
        for (int i = 0; i < 32; i++) begin
            if (o[i]) begin
                for (int d = 0; d < 4; d++) begin
                    if ((d / 2) == int'(s) || k[i]) begin
                        n1 = nb(i, d);
                        if (n1 >= 0) begin
                            if (!occ[n1]) e.mv[i] = 1'b1;
                            if (p[n1]) begin
                                n2 = nb(n1, d);
                                if (n2 >= 0 && !occ[n2]) e.jp[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
`ifdef CHK_FORCE_JUMP_EN
        if (e.jp != '0) e.mv = '0;
`endif
        e.aj = |e.jp;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] mv, jp);
        exp_t e;
        e.mv = mv;
        e.jp = jp;
        e.aj = |jp;
        return e;
    endfunction

    task automatic run_scan(input logic [31:0] o, p, k, input logic s, input exp_t e, input string name);
        int lat;
        exp_t want;
        sb.push_back(e);
        @(negedge clock);
        own = o; opp = p; kings = k; side = s; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        own = $urandom; opp = $urandom; kings = $urandom; side = 1'($urandom_range(0, 1));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b want 1", name, busy);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 30) begin
            @(posedge clock); #1;
            lat++;
        end
        checks++;
        if (lat != 13) begin
            errors++;
            $display("FAIL %s latency got %0d want 13", name, lat);
        end
        want = sb.pop_front();
        if (done === 1'b1) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done got %b want 0", name, busy);
            end
            checks++;
            if (move_mask !== want.mv) begin
                errors++;
                $display("FAIL %s move_mask got %h want %h", name, move_mask, want.mv);
            end
            checks++;
            if (jump_mask !== want.jp) begin
                errors++;
                $display("FAIL %s jump_mask got %h want %h", name, jump_mask, want.jp);
            end
            checks++;
            if (any_jump !== want.aj) begin
                errors++;
                $display("FAIL %s any_jump got %b want %b", name, any_jump, want.aj);
            end
            @(posedge clock); #1;
            checks++;
            if (done !== 1'b0 || move_mask !== want.mv) begin
                errors++;
                $display("FAIL %s done_pulse_hold got done=%b mv=%h want done=0 mv=%h",
                         name, done, move_mask, want.mv);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, any_jump, move_mask, jump_mask} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b aj=%b mv=%h jp=%h want all 0",
                     busy, done, any_jump, move_mask, jump_mask);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] mv_forced;
`ifdef CHK_FORCE_JUMP_EN
        mv_forced = 32'h0;
`else
        mv_forced = 32'h0200_0000;
`endif
        run_scan(32'h0200_0000, 32'h0, 32'h0, 1'b0, mk(32'h0200_0000, 32'h0), "single_move");
        run_scan(32'h0200_0000, 32'h0040_0000, 32'h0, 1'b0, mk(mv_forced, 32'h0200_0000), "single_jump");
        run_scan(32'h0200_0000, 32'h0048_0000, 32'h0, 1'b0, mk(32'h0200_0000, 32'h0), "jump_blocked");
        run_scan(32'h0000_0008, 32'h0, 32'h0, 1'b0, mk(32'h0, 32'h0), "border_man");
        run_scan(32'h0000_0008, 32'h0, 32'h0000_0008, 1'b0, mk(32'h0000_0008, 32'h0), "border_king");
        run_scan(32'h0, 32'hFFFF_0000, 32'h0, 1'b1, mk(32'h0, 32'h0), "empty_own");
`ifdef CHK_FORCE_JUMP_EN
        run_scan(32'h0000_0020, 32'h0000_0400, 32'h0000_0020, 1'b0, mk(32'h0, 32'h0000_0020), "king_back_jump");
`else
        run_scan(32'h0000_0020, 32'h0000_0400, 32'h0000_0020, 1'b0, mk(32'h0000_0020, 32'h0000_0020), "king_back_jump");
`endif
    endtask

    task automatic test_random();
        logic [31:0] o, p, k;
        logic s;
        for (int n = 0; n < 6; n++) begin
            o = $urandom & $urandom;
            p = $urandom & $urandom & ~o;
            k = $urandom;
            s = 1'(n % 2);
            run_scan(o, p, k, s, model(o, p, k & o, s), "random");
        end
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clock);
        own = 32'h0200_0000; opp = 32'h0040_0000; kings = '0; side = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({busy, done, any_jump, move_mask, jump_mask} !== '0) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b aj=%b mv=%h jp=%h want all 0",
                     busy, done, any_jump, move_mask, jump_mask);
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_lockout();
        int lat, dones;
        exp_t want;
        sb.push_back(mk(32'h0200_0000, 32'h0));
        @(negedge clock);
        own = 32'h0200_0000; opp = '0; kings = '0; side = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0;
        dones = 0;
        while (lat < 40) begin
            if (lat == 4) begin
                own = 32'h0000_0020; opp = 32'h0000_0400; kings = 32'h0000_0020; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            lat++;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (lat != 13) begin
                    errors++;
                    $display("FAIL lockout_latency got %0d want 13", lat);
                end
                want = sb.pop_front();
                checks++;
                if (move_mask !== want.mv || jump_mask !== want.jp || any_jump !== want.aj) begin
                    errors++;
                    $display("FAIL lockout_result got mv=%h jp=%h aj=%b want mv=%h jp=%h aj=%b",
                             move_mask, jump_mask, any_jump, want.mv, want.jp, want.aj);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL lockout_done_count got %0d want 1", dones);
            if (dones == 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_lockout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
